// File: rtl/gen_arb_wrr_if.sv
// Request/grant bundle for the weighted round-robin arbiter.
//   rqsts    : per-requester level requests
//   wgts     : per-requester weights, slice [i*CNT_WID +: CNT_WID] belongs to requester i
//   ack      : downstream accepted one transfer from the current grantee
//   grnts    : one-hot grant bus
//   grnt_vld : any grant active
//   grnt_idx : binary index of the active grant, 0 when none
// slave  : arbiter side
// master : requester / downstream side
interface gen_arb_wrr_if #(
    parameter int unsigned WID     = 16,
    parameter int unsigned CNT_WID = 4,
    parameter int unsigned IDX_WID = $clog2(WID)
);
    logic [WID-1:0]         rqsts;
    logic [WID*CNT_WID-1:0] wgts;
    logic                   ack;
    logic [WID-1:0]         grnts;
    logic                   grnt_vld;
    logic [IDX_WID-1:0]     grnt_idx;

    modport slave (
        input  rqsts,
        input  wgts,
        input  ack,
        output grnts,
        output grnt_vld,
        output grnt_idx
    );

    modport master (
        output rqsts,
        output wgts,
        output ack,
        input  grnts,
        input  grnt_vld,
        input  grnt_idx
    );
endinterface

// File: rtl/gen_arb_wrr_top.sv
// Weighted round-robin arbiter.
// A winner holds its grant for up to <weight> acknowledged transfers (weight 0 acts as 1),
// or until it drops its request. On release the next winner is loaded in the same cycle,
// searching upward from the released index and wrapping to the lowest requester.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : gen_arb_wrr_if.slave (rqsts, wgts, ack in; grnts, grnt_vld, grnt_idx out)
module gen_arb_wrr_top #(
    parameter int unsigned WID     = 16,
    parameter int unsigned CNT_WID = 4,
    parameter int unsigned IDX_WID = $clog2(WID)
) (
    input  logic           clk,
    input  logic           rst,
    gen_arb_wrr_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e               state_q;
    logic [WID-1:0]       grnts_q;
    logic                 grnt_vld_q;
    logic [IDX_WID-1:0]   grnt_idx_q;
    logic [IDX_WID-1:0]   ptr_q;
    logic [CNT_WID-1:0]   credit_q;

    logic                 rel_grant;
    logic [IDX_WID-1:0]   arb_ptr;
    logic                 win_vld;
    logic [IDX_WID-1:0]   win_idx;
    logic                 found_hi;
    logic [IDX_WID-1:0]   hi_idx;
    logic [CNT_WID-1:0]   win_wgt;
    logic [CNT_WID-1:0]   load_credit;
    logic [WID-1:0]       win_onehot;

    always_comb begin
        // Release on last credit being spent, or on the grantee dropping its request.
        rel_grant = (state_q == StHold) &&
                    ((bus.ack && (credit_q == CNT_WID'(1))) || !bus.rqsts[grnt_idx_q]);
        // A releasing grantee becomes the new priority reference in the same cycle.
        arb_ptr   = rel_grant ? grnt_idx_q : ptr_q;

        win_vld  = 1'b0;
        win_idx  = '0;
        found_hi = 1'b0;
        hi_idx   = '0;
        // Descending scans leave the lowest qualifying index in the result.
        for (int i = int'(WID) - 1; i >= 0; i--) begin
            if (bus.rqsts[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_WID'(i);
                if (i > int'(arb_ptr)) begin
                    found_hi = 1'b1;
                    hi_idx   = IDX_WID'(i);
                end
            end
        end
        if (found_hi) begin
            win_idx = hi_idx;
        end

        win_wgt     = bus.wgts[win_idx*CNT_WID +: CNT_WID];
        load_credit = (win_wgt == '0) ? CNT_WID'(1) : win_wgt;
        win_onehot  = {{(WID-1){1'b0}}, 1'b1} << win_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grnts_q    <= '0;
            grnt_vld_q <= 1'b0;
            grnt_idx_q <= '0;
            credit_q   <= '0;
            // Highest index as last-granted gives index 0 top priority.
            ptr_q      <= IDX_WID'(WID - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        state_q    <= StHold;
                        grnts_q    <= win_onehot;
                        grnt_vld_q <= 1'b1;
                        grnt_idx_q <= win_idx;
                        credit_q   <= load_credit;
                    end
                end
                StHold: begin
                    if (rel_grant) begin
                        ptr_q <= grnt_idx_q;
                        if (win_vld) begin
                            grnts_q    <= win_onehot;
                            grnt_vld_q <= 1'b1;
                            grnt_idx_q <= win_idx;
                            credit_q   <= load_credit;
                        end else begin
                            state_q    <= StIdle;
                            grnts_q    <= '0;
                            grnt_vld_q <= 1'b0;
                            grnt_idx_q <= '0;
                            credit_q   <= '0;
                        end
                    end else if (bus.ack && (credit_q != '0)) begin
                        credit_q <= credit_q - CNT_WID'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grnts    = grnts_q;
    assign bus.grnt_vld = grnt_vld_q;
    assign bus.grnt_idx = grnt_idx_q;

endmodule

// File: tb/tb_gen_arb_wrr_top.sv
// Directed bench for gen_arb_wrr_top at WID=4, CNT_WID=2.
module tb_gen_arb_wrr_top;

    localparam int unsigned WID     = 4;
    localparam int unsigned CNT_WID = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    gen_arb_wrr_if #(.WID(WID), .CNT_WID(CNT_WID)) bus ();

    gen_arb_wrr_top #(.WID(WID), .CNT_WID(CNT_WID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic v,
                               input logic [1:0] idx);
        check_eq({tag, ".grnts"}, 32'(bus.grnts), 32'(g));
        check_eq({tag, ".vld"}, 32'(bus.grnt_vld), 32'(v));
        check_eq({tag, ".idx"}, 32'(bus.grnt_idx), 32'(idx));
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        bus.rqsts = 4'b1111;
        bus.ack   = 1'b0;
        bus.wgts  = 8'b01_01_01_01;

        // Reset with all requesting
        step(); check_grant("rst0", 4'b0000, 1'b0, 2'd0);
        step(); check_grant("rst1", 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;
        step(); check_grant("first", 4'b0001, 1'b1, 2'd0);

        // Fairness, weight 1 each, ack always
        bus.ack = 1'b1;
        step(); check_grant("rr1", 4'b0010, 1'b1, 2'd1);
        step(); check_grant("rr2", 4'b0100, 1'b1, 2'd2);
        step(); check_grant("rr3", 4'b1000, 1'b1, 2'd3);
        step(); check_grant("rr0", 4'b0001, 1'b1, 2'd0);
        bus.ack   = 1'b0;
        bus.rqsts = 4'b0000;
        step(); check_grant("rr_idle", 4'b0000, 1'b0, 2'd0);

        // Weighted hold, w2=3
        bus.wgts  = 8'b01_11_01_01;
        bus.rqsts = 4'b0100;
        step(); check_grant("w_load", 4'b0100, 1'b1, 2'd2);
        bus.ack = 1'b1; step(); check_grant("w_ack1", 4'b0100, 1'b1, 2'd2);
        bus.ack = 1'b0; step(); check_grant("w_gap1", 4'b0100, 1'b1, 2'd2);
        bus.ack = 1'b1; step(); check_grant("w_ack2", 4'b0100, 1'b1, 2'd2);
        bus.ack = 1'b0; step(); check_grant("w_gap2", 4'b0100, 1'b1, 2'd2);
        // Third ack exhausts credit; sole requester reloads back-to-back
        bus.ack = 1'b1; step(); check_grant("w_reload", 4'b0100, 1'b1, 2'd2);
        // Fresh credit of 3: two more acks keep the grant; with bit 0 now also
        // requesting, the third ack hands over to it.
        step(); check_grant("w_fresh1", 4'b0100, 1'b1, 2'd2);
        bus.rqsts = 4'b0101;
        step(); check_grant("w_fresh2", 4'b0100, 1'b1, 2'd2);
        step(); check_grant("w_handoff", 4'b0001, 1'b1, 2'd0);
        bus.ack   = 1'b0;
        bus.rqsts = 4'b0000;
        step(); check_grant("w_idle", 4'b0000, 1'b0, 2'd0);

        // Drop scenario, w1=3; pointer is now 0 so index 1 wins
        bus.wgts  = 8'b01_01_11_01;
        bus.rqsts = 4'b0110;
        step(); check_grant("d_load", 4'b0010, 1'b1, 2'd1);
        bus.ack = 1'b1; step(); check_grant("d_ack", 4'b0010, 1'b1, 2'd1);
        // Drop with ack in the same cycle: single release, next is index 2
        bus.rqsts = 4'b0100;
        step(); check_grant("d_drop", 4'b0100, 1'b1, 2'd2);
        bus.ack   = 1'b0;
        bus.rqsts = 4'b0000;
        step(); check_grant("d_idle", 4'b0000, 1'b0, 2'd0);

        // Zero weight: acts as 1, re-grant every cycle
        bus.wgts  = 8'b01_01_01_00;
        bus.rqsts = 4'b0001;
        bus.ack   = 1'b1;
        step(); check_grant("z_load", 4'b0001, 1'b1, 2'd0);
        step(); check_grant("z_re1", 4'b0001, 1'b1, 2'd0);
        // Bit 1 joins; one ack on bit 0 must hand over immediately
        bus.rqsts = 4'b0011;
        step(); check_grant("z_hand", 4'b0010, 1'b1, 2'd1);
        bus.rqsts = 4'b0001;
        step(); check_grant("z_back", 4'b0001, 1'b1, 2'd0);

        // Reset during hold drops the grant at the next edge
        rst = 1'b1;
        step(); check_grant("hr_rst", 4'b0000, 1'b0, 2'd0);
        bus.ack = 1'b0;
        rst     = 1'b0;
        step(); check_grant("hr_again", 4'b0001, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gen_arb_wrr_top.md
GEN_ARB_WRR_TOP -- requirements
Module: gen_arb_wrr_top

Interface
REQ-001 The block SHALL have parameter WID, default 16, setting the width in bits of the request and grant buses.
REQ-002 The block SHALL have parameter CNT_WID, default 4, setting the width in bits of each per-requester weight.
REQ-003 The block SHALL have parameter IDX_WID, default $clog2(WID), setting the width of the grant index.
REQ-004 clk  input  1  Clock; one clock domain.
REQ-005 rst  input  1  Reset; synchronous, active-high.
REQ-006 rqsts  input  WID  Request bus; bit i is requester i's level request.
REQ-007 wgts  input  WID*CNT_WID  Weights; slice [i*CNT_WID +: CNT_WID] belongs to requester i.
REQ-008 ack  input  1  Downstream accepts one transfer from the current grantee this cycle.
REQ-009 grnts  output  WID  Registered one-hot grant bus.
REQ-010 grnt_vld  output  1  Registered; equals |grnts.
REQ-011 grnt_idx  output  IDX_WID  Registered binary index of the set grnts bit; 0 when grnt_vld=0.

Function
REQ-012 The block SHALL implement two states: IDLE (no grant) and HOLD (one grant active).
REQ-013 Arbitration SHALL be round-robin over a ring, with priority as follows:
- candidates are the rqsts bits strictly above the last granted index, lowest index first;
- if there are none, the lowest set rqsts bit wins.
REQ-014 The last-granted pointer SHALL reset so that index 0 has top priority.
REQ-015 IDLE: if rqsts != 0 in cycle N, the winner's grnts/grnt_vld/grnt_idx SHALL be set from the edge ending cycle N (visible in N+1), and the state SHALL go to HOLD.
REQ-016 On grant load, a credit counter SHALL be loaded with the winner's weight, and a weight of 0 SHALL load as 1.
REQ-017 Weight changes during HOLD SHALL have no effect until the next grant load.
REQ-018 HOLD: each cycle with ack=1 SHALL decrement credit by 1.
REQ-019 Credit SHALL never underflow.
REQ-020 ack SHALL be ignored while grnt_vld=0.
REQ-021 HOLD SHALL release the grant in a cycle where either:
- ack=1 and credit=1; or
- rqsts[grnt_idx]=0.
REQ-022 On release, the pointer SHALL update to the released index.
REQ-023 On release, a new arbitration SHALL be performed in the same cycle using the updated pointer and current rqsts, with the released bit excluded when it is dropping.
REQ-024 The result of a release SHALL be:
- if a winner exists, the next grant is loaded with no bubble and the state stays in HOLD;
- otherwise grnts=0 and the state goes to IDLE.
REQ-025 If the sole requester is released by credit exhaustion while still requesting, it SHALL be re-granted back-to-back with fresh credit.
REQ-026 If ack=1 and rqsts[grnt_idx]=0 in the same cycle, the ack SHALL be counted and the grant released once.
REQ-027 grnts SHALL be one-hot or zero in every cycle.
REQ-028 grnts SHALL change only on release or from IDLE.

Reset
REQ-029 While rst=1 at an edge, the following SHALL be cleared:
- grnts=0, grnt_vld=0, grnt_idx=0;
- credit=0;
- state=IDLE;
- pointer set so that index 0 has top priority.
REQ-030 Reset asserted during HOLD SHALL drop the grant at the next edge, with no ack counted.
REQ-031 The first arbitration SHALL occur in the first cycle with rst=0.

Verification (WID=4, CNT_WID=2)
REQ-032 Reset scenario: rst=1 for 2 cycles with rqsts=1111, then rst=0 -> grnts=0000 throughout reset, and grnts=0001 in the cycle after the first rst=0 cycle.
REQ-033 Fairness scenario: all weights 1, rqsts=1111, ack=1 constantly -> grnts sequence 0001, 0010, 0100, 1000, 0001, each held 1 cycle.
REQ-034 Weighted hold scenario: w2=3, rqsts=0100, ack pulsed 3 times with gaps -> grnts=0100 held through all 3 acks, then reloaded back-to-back as 0100.
REQ-035 Drop scenario: w1=3, grant 0010, rqsts drops from 0110 to 0100 after 1 ack -> next cycle grnts=0100, grnt_idx=2.
REQ-036 Zero-weight and mid-hold reset scenario: w0=0, rqsts=0001, ack=1 -> re-grant every cycle; then rst=1 during HOLD -> grnts=0000 at the next edge.
